// File: rtl/con_ff_param.sv
// con_ff_param: parametrised branch-condition unit for the mini CPU datapath.
// Decodes the IR condition field against the current bus value on CONin.
// Holds the registered decision behind a valid/ack handshake for the
// control sequencer. Also keeps saturating evaluated/taken statistics.
// COND_W may be 2 (codes 0-3) or 3 (extended codes 0-7).

module con_ff_param #(
    parameter int DATA_W   = 32,
    parameter int IR_W     = 32,
    parameter int COND_LSB = 19,
    parameter int COND_W   = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [IR_W-1:0]   ir,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              CONin,
    input  logic              con_ack,
    input  logic              stat_clr,
    output logic              con,
    output logic              con_valid,
    output logic [COND_W-1:0] cond_q,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  eval_cnt
);

    // IDLE: no unconsumed decision. VALID: con holds a decision not yet acked.
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [COND_W-1:0] cond_code;
    logic [2:0]        code_ext;
    logic              is_zero;
    logic              is_neg;
    logic              decision;
    logic              con_next;
    logic              valid_next;
    logic [COND_W-1:0] cond_next;

    // Only the condition field of ir matters here; the rest is reduced to a
    // sink so the remaining instruction bits are visibly intentional.
    logic              unused_ir;
    assign unused_ir = ^ir;

    // Condition decode, purely combinational from the live ir and bus value.
    // The field is zero-extended to 3 bits so a single table serves both
    // widths; with COND_W=2 codes 4-7 simply cannot occur.
    always_comb begin
        cond_code = ir[COND_LSB +: COND_W];
        code_ext  = 3'b000;
        code_ext[COND_W-1:0] = cond_code;
        is_zero   = (BusMuxOut == '0);
        is_neg    = BusMuxOut[DATA_W-1];
        decision  = 1'b0;
        case (code_ext)
            3'd0:    decision = is_zero;
            3'd1:    decision = !is_zero;
            3'd2:    decision = !is_neg;
            3'd3:    decision = is_neg;
            3'd4:    decision = !is_neg && !is_zero;
            3'd5:    decision = is_neg || is_zero;
            3'd6:    decision = 1'b1;
            3'd7:    decision = 1'b0;
            default: decision = 1'b0;
        endcase
    end

    // Handshake next-state: a strobe always latches a fresh decision and
    // (re)enters VALID, so it beats a simultaneous ack; an ack alone only
    // retires VALID, and con/cond_q keep their last values.
    always_comb begin
        state_next = state;
        con_next   = con;
        cond_next  = cond_q;
        if (CONin) begin
            con_next  = decision;
            cond_next = cond_code;
        end
        case (state)
            IDLE: begin
                if (CONin) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                if (!CONin && con_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        valid_next = (state_next == VALID);
    end

    // Decision registers; clear discards any pending decision immediately.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            con       <= 1'b0;
            cond_q    <= '0;
            con_valid <= 1'b0;
        end else begin
            state     <= state_next;
            con       <= con_next;
            cond_q    <= cond_next;
            con_valid <= valid_next;
        end
    end

    // Saturating statistics; stat_clr takes priority over a same-cycle strobe.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (stat_clr) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (CONin) begin
            if (eval_cnt != CNT_MAX) begin
                eval_cnt <= eval_cnt + CNT_ONE;
            end
            if (decision && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end

endmodule
